// File: rtl/mac_layer_sequencer_if.sv
// Handshake and SRAM bus bundle for the fully-connected layer sequencer.
// The master is the network controller plus the SRAMs; the slave is the sequencer.
interface mac_layer_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic                       start;
    logic [ADDR_W-1:0]          n_in;
    logic [ADDR_W-1:0]          n_out;
    logic                       busy;
    logic                       done;
    logic                       in_rd;
    logic [ADDR_W-1:0]          in_addr;
    logic                       w_rd;
    logic [2*ADDR_W-1:0]        w_addr;
    logic signed [DATA_W-1:0]   in_data;
    logic signed [DATA_W-1:0]   w_data;
    logic                       out_we;
    logic [ADDR_W-1:0]          out_addr;
    logic signed [DATA_W-1:0]   out_data;

    modport master (
        output start, n_in, n_out, in_data, w_data,
        input  busy, done, in_rd, in_addr, w_rd, w_addr,
        input  out_we, out_addr, out_data
    );

    modport slave (
        input  start, n_in, n_out, in_data, w_data,
        output busy, done, in_rd, in_addr, w_rd, w_addr,
        output out_we, out_addr, out_data
    );
endinterface

// File: rtl/mac_layer_sequencer.sv
// Fully-connected layer sequencer: streams inputs and weights, accumulates,
// then writes ReLU + rescaled + saturated neuron values to the output SRAM.
module mac_layer_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 36,
    parameter int FRAC   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_layer_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t state, nxt;

    logic [ADDR_W-1:0]        i, o, nin_q, nout_q;
    logic [ADDR_W-1:0]        last_i, last_o;
    logic [ADDR_W-1:0]        oaddr_q;
    logic signed [DATA_W-1:0] odata_q, act;
    logic signed [ACC_W-1:0]  acc, sh, prod_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic                     vld, rd, we, bsy, dn;
    logic                     accept;

    assign last_i = nin_q - {{(ADDR_W-1){1'b0}}, 1'b1};
    assign last_o = nout_q - {{(ADDR_W-1){1'b0}}, 1'b1};
    assign accept = (state == IDLE) && bus.start;

    always_comb begin
        nxt = state;
        rd  = 1'b0;
        we  = 1'b0;
        bsy = 1'b1;
        dn  = 1'b0;
        unique case (state)
            IDLE: begin
                bsy = 1'b0;
                if (bus.start) begin
                    if (bus.n_in != '0 && bus.n_out != '0)
                        nxt = FETCH;
                    else
                        nxt = DONE;
                end
            end
            FETCH: begin
                rd = 1'b1;
                if (i == last_i) nxt = DRAIN;
            end
            DRAIN: nxt = WRITE;
            WRITE: begin
                we  = 1'b1;
                nxt = (o == last_o) ? DONE : FETCH;
            end
            DONE: begin
                dn  = 1'b1;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    assign prod     = $signed(bus.in_data) * $signed(bus.w_data);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign sh       = acc >>> FRAC;

    // sh is non-negative when used, so any set bit at or above DATA_W-1 overflows
    always_comb begin
        act = '0;
        if (!acc[ACC_W-1]) begin
            if (|sh[ACC_W-1:DATA_W-1])
                act = {1'b0, {(DATA_W-1){1'b1}}};
            else
                act = sh[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i       <= '0;
            o       <= '0;
            nin_q   <= '0;
            nout_q  <= '0;
            acc     <= '0;
            vld     <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
        end else begin
            vld <= rd;
            if (accept) begin
                nin_q  <= bus.n_in;
                nout_q <= bus.n_out;
                i      <= '0;
                o      <= '0;
                acc    <= '0;
            end
            if (rd)  i   <= i + 1'b1;
            if (vld) acc <= acc + prod_ext;
            if (we) begin
                acc     <= '0;
                i       <= '0;
                oaddr_q <= o;
                odata_q <= act;
                if (o != last_o) o <= o + 1'b1;
            end
        end
    end

    assign bus.busy     = bsy;
    assign bus.done     = dn;
    assign bus.in_rd    = rd;
    assign bus.w_rd     = rd;
    assign bus.in_addr  = i;
    assign bus.w_addr   = {{ADDR_W{1'b0}}, o} * {{ADDR_W{1'b0}}, nin_q}
                        + {{ADDR_W{1'b0}}, i};
    assign bus.out_we   = we;
    assign bus.out_addr = we ? o : oaddr_q;
    assign bus.out_data = we ? act : odata_q;
endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Self-checking bench for mac_layer_sequencer: directed table, corner
// sequences and randomized layers against a dot-product reference model.
module tb_mac_layer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mac_layer_sequencer_if #(.DATA_W(16), .ADDR_W(4)) bus();

    mac_layer_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [15:0] in_mem [16];
    logic signed [15:0] w_mem  [256];

    always @(posedge clk) begin
        if (bus.in_rd) bus.in_data <= in_mem[bus.in_addr];
        if (bus.w_rd)  bus.w_data  <= w_mem[bus.w_addr];
    end

    typedef struct {
        int          a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int ni;
        int no;
        int mode;
        int pulse;
        int lat;
    } vec_t;

    wr_t  wq[$];
    int   rd_cnt;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_we) wq.push_back('{int'(bus.out_addr), bus.out_data});
        if (bus.in_rd) rd_cnt++;
        if (bus.in_rd || bus.w_rd)
            chk("w_rd_eq_in_rd", int'(bus.w_rd), int'(bus.in_rd));
    end

    function automatic logic [15:0] model(input int ni, input int o);
        longint s = 0;
        for (int k = 0; k < ni; k++)
            s += longint'(int'(in_mem[k]) * int'(w_mem[o*ni+k]));
        if (s < 0) return 16'h0000;
        s = s / 256;
        if (s > 32767) return 16'h7fff;
        return 16'(s);
    endfunction

    task automatic fill(input int mode);
        for (int k = 0; k < 16; k++) begin
            unique case (mode)
                0: in_mem[k] = 16'($urandom);
                1: in_mem[k] = 16'h7fff;
                3: in_mem[k] = 16'($urandom_range(511)) - 16'sd256;
                default: in_mem[k] = '0;
            endcase
        end
        for (int k = 0; k < 256; k++) begin
            unique case (mode)
                0: w_mem[k] = 16'($urandom);
                1: w_mem[k] = 16'h7fff;
                3: w_mem[k] = 16'($urandom_range(511)) - 16'sd256;
                default: w_mem[k] = '0;
            endcase
        end
        if (mode == 2) begin
            in_mem[0] = 16'h0100; in_mem[1] = 16'h0200; in_mem[2] = 16'hff00;
            w_mem[0]  = 16'h0100; w_mem[1]  = 16'h0100; w_mem[2]  = 16'h0100;
            w_mem[3]  = 16'h0080; w_mem[4]  = 16'h0000; w_mem[5]  = 16'h0200;
        end
    endtask

    task automatic check_writes(input int ni, input int no, input string tag);
        int nw;
        nw = (ni == 0 || no == 0) ? 0 : no;
        chk({tag, "_nwrites"}, wq.size(), nw);
        chk({tag, "_nreads"}, rd_cnt, ni * no * (nw != 0 ? 1 : 0));
        for (int k = 0; k < wq.size() && k < nw; k++) begin
            chk({tag, "_waddr"}, wq[k].a, k);
            chk({tag, "_wdata"}, int'(wq[k].d), int'(model(ni, k)));
        end
    endtask

    task automatic wait_done(input int pulse, output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == pulse);
            if (cyc == pulse) begin
                bus.n_in  = 4'd2;
                bus.n_out = 4'd1;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic run_layer(input int ni, input int no, input int pulse,
                             input int lat, input string tag);
        int cyc;
        wq.delete();
        rd_cnt = 0;
        bus.start = 1'b1;
        bus.n_in  = 4'(ni);
        bus.n_out = 4'(no);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_first_rd"}, int'(bus.in_rd), (ni != 0 && no != 0) ? 1 : 0);
        wait_done(pulse, cyc);
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_busy_at_done"}, int'(bus.busy), 1);
        check_writes(ni, no, tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(bus.done), 0);
        chk({tag, "_idle_busy"}, int'(bus.busy), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_in_rd"}, int'(bus.in_rd), 0);
        chk({tag, "_w_rd"}, int'(bus.w_rd), 0);
        chk({tag, "_out_we"}, int'(bus.out_we), 0);
        chk({tag, "_in_addr"}, int'(bus.in_addr), 0);
        chk({tag, "_w_addr"}, int'(bus.w_addr), 0);
        chk({tag, "_out_addr"}, int'(bus.out_addr), 0);
        chk({tag, "_out_data"}, int'($unsigned(bus.out_data)), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int ni, no;
        bus.start = 1'b0;
        bus.n_in  = '0;
        bus.n_out = '0;
        bus.in_data = '0;
        bus.w_data  = '0;
        rd_cnt = 0;
        tbl[0] = '{3, 2, 2, -1, 10};
        tbl[1] = '{12, 5, 1, -1, 70};
        tbl[2] = '{0, 3, 3, -1, 0};
        tbl[3] = '{4, 0, 3, -1, 0};
        tbl[4] = '{5, 3, 3, 7, 21};
        tbl[5] = '{15, 15, 3, -1, 255};
        tbl[6] = '{1, 1, 0, -1, 3};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            fill(tbl[t].mode);
            run_layer(tbl[t].ni, tbl[t].no, tbl[t].pulse, tbl[t].lat,
                      $sformatf("vec%0d", t));
            if (tbl[t].mode == 2 && wq.size() == 2) begin
                chk("t1_out0", int'(wq[0].d), 16'h0200);
                chk("t1_out1", int'(wq[1].d), 16'h0000);
            end
            if (tbl[t].mode == 1)
                foreach (wq[k]) chk("sat_out", int'(wq[k].d), 16'h7fff);
        end

        // abort mid-FETCH of neuron 1
        fill(3);
        bus.start = 1'b1;
        bus.n_in  = 4'd4;
        bus.n_out = 4'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        c = 0;
        while (!bus.out_we && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("rst_first_write_seen", int'(bus.out_we), 1);
        @(negedge clk);
        chk("rst_in_fetch", int'(bus.in_rd), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        wq.delete();
        rd_cnt = 0;
        repeat (20) @(negedge clk);
        chk("midrst_no_writes", wq.size(), 0);
        chk("midrst_no_reads", rd_cnt, 0);
        run_layer(4, 3, -1, 18, "after_rst");

        // start held high across two layers with sizes changed at done
        fill(3);
        wq.delete();
        rd_cnt = 0;
        bus.start = 1'b1;
        bus.n_in  = 4'd12;
        bus.n_out = 4'd5;
        @(posedge clk);
        @(negedge clk);
        c = 0;
        while (!bus.done && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk("held_l1_latency", c, 70);
        check_writes(12, 5, "held_l1");
        wq.delete();
        rd_cnt = 0;
        bus.n_in  = 4'd4;
        bus.n_out = 4'd2;
        @(negedge clk);
        chk("held_idle_gap", int'(bus.busy), 0);
        @(negedge clk);
        chk("held_l2_first_rd", int'(bus.in_rd), 1);
        chk("held_l2_waddr0", int'(bus.w_addr), 0);
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk("held_l2_latency", c, 12);
        check_writes(4, 2, "held_l2");
        @(negedge clk);

        // randomized layers
        for (int r = 0; r < 12; r++) begin
            fill((r % 3 == 0) ? 0 : 3);
            ni = $urandom_range(15, 1);
            no = $urandom_range(15, 1);
            run_layer(ni, no, -1, no * (ni + 2), $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
